// File: rtl/metronomo_pkg.sv
// Shared state encoding, period type, default tempo limits and small
// clamping helpers for the metronome beat generator.
package metronomo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_RUN     = 2'd2,
      ST_CALC_BG = 2'd3
   } state_t;

   typedef logic [31:0] period_t;

   localparam int unsigned DEF_BPM_MIN = 30;
   localparam int unsigned DEF_BPM_MAX = 250;

   function automatic period_t clamp_u32(input period_t v, input period_t lo, input period_t hi);
      if (v < lo) return lo;
      else if (v > hi) return hi;
      else return v;
   endfunction

   // Subdivision factors outside 1..4 fall back to plain beats.
   function automatic logic [2:0] clamp_subdiv(input logic [2:0] s);
      return (s == 3'd0 || s > 3'd4) ? 3'd1 : s;
   endfunction

endpackage

// File: rtl/metronomo_seq_div.sv
// Sequential restoring divider: one load cycle, then 32 iteration cycles;
// done pulses for one cycle while quotient holds the result.
module metronomo_seq_div
   import metronomo_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    start,
   input  logic    abort,
   input  period_t dividend,
   input  period_t divisor,
   output logic    busy,
   output logic    done,
   output period_t quotient
);

   logic [32:0] rem_reg;
   period_t     quo_reg;
   period_t     dvs_reg;
   logic [5:0]  cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [32:0] shifted;
   logic [32:0] diff;

   // The dividend shifts out of quo_reg as quotient bits shift in.
   always_comb begin
      shifted = {rem_reg[31:0], quo_reg[31]};
      diff    = shifted - {1'b0, dvs_reg};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         dvs_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (abort) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
         end else if (start && !busy_reg) begin
            quo_reg  <= dividend;
            dvs_reg  <= divisor;
            rem_reg  <= '0;
            cnt_reg  <= 6'd32;
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            rem_reg  <= diff[32] ? shifted : diff;
            quo_reg  <= {quo_reg[30:0], ~diff[32]};
            cnt_reg  <= cnt_reg - 6'd1;
            if (cnt_reg == 6'd1) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign quotient = quo_reg;

endmodule

// File: rtl/metronomo_beat_gen.sv
// Metronome beat generator: derives the beat period from a BPM tempo with a
// sequential divider, then emits tick/accent pulses. Defining
// METRONOMO_SUBDIV_EN adds the subdiv input and sub_tick output.
module metronomo_beat_gen
   import metronomo_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned BPM_W   = 8,
   parameter int unsigned BPM_MIN = DEF_BPM_MIN,
   parameter int unsigned BPM_MAX = DEF_BPM_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [BPM_W-1:0] bpm,
   input  logic [2:0]       beats_per_meas,
`ifdef METRONOMO_SUBDIV_EN
   input  logic [2:0]       subdiv,
   output logic             sub_tick,
`endif
   output logic             tick,
   output logic             accent,
   output logic [2:0]       beat_idx,
   output logic [31:0]      period,
   output logic             period_valid
);

   localparam logic [63:0] NUMER_W = 64'(CLK_HZ) * 64'd60;
   localparam period_t     NUMER   = NUMER_W[31:0];

   generate
      if (NUMER_W >= 64'h1_0000_0000 || BPM_MIN == 0 || BPM_MIN > BPM_MAX ||
          NUMER_W < 64'(BPM_MAX)) begin : g_bad_cfg
         $error("metronomo_beat_gen: invalid CLK_HZ / BPM_MIN / BPM_MAX");
      end
   endgenerate

   state_t     state_reg, state_next;
   period_t    bpm_lat_reg, bpm_lat_next;
   period_t    period_reg, period_next;
   logic       period_valid_reg, period_valid_next;
   period_t    pend_period_reg, pend_period_next;
   logic       pend_valid_reg, pend_valid_next;
   period_t    count_reg, count_next;
   logic [2:0] beat_idx_reg, beat_idx_next;
   logic       tick_reg, tick_next;
   logic       accent_reg, accent_next;

   logic       div_start, div_abort, div_busy, div_done;
   period_t    div_dividend, div_divisor, div_quotient;
   period_t    bpm_clamped;
   logic       calc_final;
   period_t    fin_period;
   logic       beat_end;
   logic [2:0] meas_eff;
   logic [2:0] idx_new;

`ifdef METRONOMO_SUBDIV_EN
   logic [2:0] subdiv_clamped;
   logic [2:0] subdiv_lat_reg, subdiv_lat_next;
   logic       calc_phase_reg, calc_phase_next;
   period_t    calc_q_reg, calc_q_next;
   period_t    sub_period_reg, sub_period_next;
   logic [2:0] sub_n_reg, sub_n_next;
   period_t    pend_sub_reg, pend_sub_next;
   logic [2:0] pend_sub_n_reg, pend_sub_n_next;
   period_t    sub_cnt_reg, sub_cnt_next;
   logic [2:0] sub_idx_reg, sub_idx_next;
   logic       sub_tick_reg, sub_tick_next;

   assign subdiv_clamped = clamp_subdiv(subdiv);
`endif

   assign bpm_clamped = clamp_u32(period_t'(bpm), BPM_MIN, BPM_MAX);

   metronomo_seq_div u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .abort    (div_abort),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   always_comb begin
      state_next        = state_reg;
      bpm_lat_next      = bpm_lat_reg;
      period_next       = period_reg;
      period_valid_next = period_valid_reg;
      pend_period_next  = pend_period_reg;
      pend_valid_next   = pend_valid_reg;
      count_next        = count_reg;
      beat_idx_next     = beat_idx_reg;
      tick_next         = 1'b0;
      accent_next       = 1'b0;
      div_start         = 1'b0;
      div_abort         = 1'b0;
      div_dividend      = NUMER;
      div_divisor       = bpm_clamped;
      calc_final        = 1'b0;
      fin_period        = div_quotient;
      beat_end          = (count_reg >= period_reg - 32'd1);
      meas_eff          = (beats_per_meas == 3'd0) ? 3'd1 : beats_per_meas;
      idx_new           = (beat_idx_reg >= meas_eff - 3'd1) ? 3'd0 : beat_idx_reg + 3'd1;
`ifdef METRONOMO_SUBDIV_EN
      subdiv_lat_next   = subdiv_lat_reg;
      calc_phase_next   = calc_phase_reg;
      calc_q_next       = calc_q_reg;
      sub_period_next   = sub_period_reg;
      sub_n_next        = sub_n_reg;
      pend_sub_next     = pend_sub_reg;
      pend_sub_n_next   = pend_sub_n_reg;
      sub_cnt_next      = sub_cnt_reg;
      sub_idx_next      = sub_idx_reg;
      sub_tick_next     = 1'b0;
`endif

      if (!en) begin
         state_next        = ST_IDLE;
         period_next       = '0;
         period_valid_next = 1'b0;
         pend_valid_next   = 1'b0;
         count_next        = '0;
         beat_idx_next     = '0;
         div_abort         = 1'b1;
`ifdef METRONOMO_SUBDIV_EN
         calc_phase_next   = 1'b0;
         sub_cnt_next      = '0;
         sub_idx_next      = '0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               div_start    = 1'b1;
               bpm_lat_next = bpm_clamped;
               state_next   = ST_CALC;
`ifdef METRONOMO_SUBDIV_EN
               subdiv_lat_next = subdiv_clamped;
               calc_phase_next = 1'b0;
`endif
            end
            ST_RUN: begin
`ifdef METRONOMO_SUBDIV_EN
               if ((bpm_clamped != bpm_lat_reg || subdiv_clamped != subdiv_lat_reg) && !div_busy) begin
                  subdiv_lat_next = subdiv_clamped;
                  calc_phase_next = 1'b0;
`else
               if (bpm_clamped != bpm_lat_reg && !div_busy) begin
`endif
                  div_start    = 1'b1;
                  bpm_lat_next = bpm_clamped;
                  state_next   = ST_CALC_BG;
               end
            end
            default: begin
               if (div_done) begin
`ifdef METRONOMO_SUBDIV_EN
                  // Second pass divides the fresh period by the subdivision.
                  if (!calc_phase_reg) begin
                     calc_q_next     = div_quotient;
                     calc_phase_next = 1'b1;
                     div_start       = 1'b1;
                     div_dividend    = div_quotient;
                     div_divisor     = period_t'(subdiv_lat_reg);
                  end else begin
                     calc_final = 1'b1;
                     fin_period = calc_q_reg;
                  end
`else
                  calc_final = 1'b1;
`endif
               end
            end
         endcase

         if (state_reg == ST_RUN || state_reg == ST_CALC_BG) begin
            if (beat_end) begin
               count_next    = '0;
               tick_next     = 1'b1;
               beat_idx_next = idx_new;
               accent_next   = (idx_new == 3'd0);
               if (pend_valid_reg) begin
                  period_next     = pend_period_reg;
                  pend_valid_next = 1'b0;
`ifdef METRONOMO_SUBDIV_EN
                  sub_period_next = pend_sub_reg;
                  sub_n_next      = pend_sub_n_reg;
`endif
               end
`ifdef METRONOMO_SUBDIV_EN
               sub_tick_next = 1'b1;
               sub_cnt_next  = '0;
               sub_idx_next  = '0;
`endif
            end else begin
               count_next = count_reg + 32'd1;
`ifdef METRONOMO_SUBDIV_EN
               if (sub_period_reg != '0 && sub_idx_reg < sub_n_reg - 3'd1 &&
                   sub_cnt_reg >= sub_period_reg - 32'd1) begin
                  sub_tick_next = 1'b1;
                  sub_cnt_next  = '0;
                  sub_idx_next  = sub_idx_reg + 3'd1;
               end else begin
                  sub_cnt_next = sub_cnt_reg + 32'd1;
               end
`endif
            end
         end

         // A foreground result starts the beat at once; a background one waits for the boundary.
         if (calc_final) begin
            state_next = ST_RUN;
            if (state_reg == ST_CALC) begin
               period_next       = fin_period;
               period_valid_next = 1'b1;
               count_next        = '0;
               beat_idx_next     = '0;
               tick_next         = 1'b1;
               accent_next       = 1'b1;
`ifdef METRONOMO_SUBDIV_EN
               sub_period_next   = div_quotient;
               sub_n_next        = subdiv_lat_reg;
               sub_tick_next     = 1'b1;
               sub_cnt_next      = '0;
               sub_idx_next      = '0;
`endif
            end else begin
               pend_period_next = fin_period;
               pend_valid_next  = 1'b1;
`ifdef METRONOMO_SUBDIV_EN
               pend_sub_next    = div_quotient;
               pend_sub_n_next  = subdiv_lat_reg;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         bpm_lat_reg      <= '0;
         period_reg       <= '0;
         period_valid_reg <= 1'b0;
         pend_period_reg  <= '0;
         pend_valid_reg   <= 1'b0;
         count_reg        <= '0;
         beat_idx_reg     <= '0;
         tick_reg         <= 1'b0;
         accent_reg       <= 1'b0;
`ifdef METRONOMO_SUBDIV_EN
         subdiv_lat_reg   <= 3'd1;
         calc_phase_reg   <= 1'b0;
         calc_q_reg       <= '0;
         sub_period_reg   <= '0;
         sub_n_reg        <= 3'd1;
         pend_sub_reg     <= '0;
         pend_sub_n_reg   <= 3'd1;
         sub_cnt_reg      <= '0;
         sub_idx_reg      <= '0;
         sub_tick_reg     <= 1'b0;
`endif
      end else begin
         state_reg        <= state_next;
         bpm_lat_reg      <= bpm_lat_next;
         period_reg       <= period_next;
         period_valid_reg <= period_valid_next;
         pend_period_reg  <= pend_period_next;
         pend_valid_reg   <= pend_valid_next;
         count_reg        <= count_next;
         beat_idx_reg     <= beat_idx_next;
         tick_reg         <= tick_next;
         accent_reg       <= accent_next;
`ifdef METRONOMO_SUBDIV_EN
         subdiv_lat_reg   <= subdiv_lat_next;
         calc_phase_reg   <= calc_phase_next;
         calc_q_reg       <= calc_q_next;
         sub_period_reg   <= sub_period_next;
         sub_n_reg        <= sub_n_next;
         pend_sub_reg     <= pend_sub_next;
         pend_sub_n_reg   <= pend_sub_n_next;
         sub_cnt_reg      <= sub_cnt_next;
         sub_idx_reg      <= sub_idx_next;
         sub_tick_reg     <= sub_tick_next;
`endif
      end
   end

   assign tick         = tick_reg;
   assign accent       = accent_reg;
   assign beat_idx     = beat_idx_reg;
   assign period       = period_reg;
   assign period_valid = period_valid_reg;
`ifdef METRONOMO_SUBDIV_EN
   assign sub_tick     = sub_tick_reg;
`endif

endmodule

// File: doc/metronomo_beat_gen.md
METRONOMO_BEAT_GEN -- requirements
Module: metronomo_beat_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BPM_W, default 8, width of the bpm input.
REQ-003 SHALL have parameter BPM_MIN, default 30, lowest accepted tempo.
REQ-004 SHALL have parameter BPM_MAX, default 250, highest accepted tempo.
REQ-005 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1  run request; low stops the metronome.
REQ-008 SHALL have port bpm  input  BPM_W  requested tempo in beats per minute.
REQ-009 SHALL have port beats_per_meas  input  3  beats per measure, 1..7.
REQ-010 SHALL have port tick  output  1  one-cycle pulse per beat.
REQ-011 SHALL have port accent  output  1  one-cycle pulse coincident with tick on the first beat of a measure.
REQ-012 SHALL have port beat_idx  output  3  index of the current beat in the measure.
REQ-013 SHALL have port period  output  32  active beat period in clk cycles.
REQ-014 SHALL have port period_valid  output  1  high while period holds a computed value.

Function
REQ-015 SHALL clamp bpm to [BPM_MIN, BPM_MAX] before use.
REQ-016 SHALL compute period = floor(CLK_HZ*60 / clamped bpm) exactly, with a 32-bit unsigned numerator.
REQ-017 SHALL use a sequential restoring divider: 1 load cycle plus 32 iteration cycles; no combinational divide.
REQ-018 SHALL implement FSM IDLE -> CALC -> RUN; RUN -> CALC_BG -> RUN for tempo changes; any state -> IDLE when en is low.
REQ-019 SHALL leave IDLE when en is high, latching the clamped bpm and entering CALC.
REQ-020 SHALL assert tick and accent in the first RUN cycle after CALC, with beat_idx = 0 (immediate downbeat).
REQ-021 SHALL count clk cycles in RUN and assert tick every period cycles thereafter.
REQ-022 SHALL advance beat_idx on each tick and wrap it to 0 after beats_per_meas-1; accent accompanies tick when the new beat_idx is 0.
REQ-023 SHALL treat beats_per_meas = 0 as 1, so every tick carries accent.
REQ-024 SHALL sample beats_per_meas only at a tick.
REQ-025 SHALL, in RUN, start a background calculation when the clamped bpm differs from the latched value, with beats uninterrupted.
REQ-026 SHALL apply a new period only at the next beat boundary after its calculation completes; the beat in progress keeps the old period.
REQ-027 SHALL, if bpm changes again during a calculation, finish it, then recalculate with the latest value.
REQ-028 SHALL keep period_valid high through background calculations; period changes only at a beat boundary.
REQ-029 SHALL, on en low, go to IDLE in the next cycle: counter 0, beat_idx 0, tick/accent low, period_valid low, no pending calculation.
REQ-030 SHALL reject at elaboration any CLK_HZ*60 >= 2^32 and any BPM_MIN of 0 or BPM_MIN > BPM_MAX.

Reset
REQ-031 SHALL, on rst high, immediately force IDLE, tick 0, accent 0, beat_idx 0, period 0, period_valid 0, and clear the counter and divider.
REQ-032 SHALL, on reset release with en high, enter CALC on the first clk edge.

Configuration
REQ-033 SHALL, with METRONOMO_SUBDIV_EN defined, add input subdiv[2:0] (1..4, 0 and values above 4 treated as 1) and output sub_tick.
REQ-034 SHALL, with the macro defined, compute sub_period = floor(period/subdiv) in a second 33-cycle divider pass; sub_tick pulses at counts 0, sub_period, 2*sub_period... below period, and coincides with every tick.
REQ-035 SHALL, without the macro, omit subdiv and sub_tick and skip the second pass.

Structure
REQ-036 SHALL place the FSM state enum, the 32-bit period type and the default BPM_MIN/BPM_MAX constants in package metronomo_pkg.
REQ-037 SHALL implement the divider as sub-module metronomo_seq_div: start/busy/done handshake, 32-bit dividend and divisor, 32-bit quotient.

Verification (CLK_HZ=1000)
REQ-038 SHALL verify: en=1, bpm=60 -> period=1000; first tick+accent 34 cycles after en; next ticks every 1000 cycles.
REQ-039 SHALL verify: bpm=10 -> period=2000 (clamp at 30); bpm=255 -> period=240 (clamp at 250).
REQ-040 SHALL verify: beats_per_meas=3, bpm=120 -> ticks every 500 cycles; beat_idx 0,1,2,0; accent on beat_idx 0 only.
REQ-041 SHALL verify: RUN at bpm=60, bpm set to 120 mid-beat -> current beat ends at 1000 cycles, next beat lasts 500 cycles, no missed tick.
REQ-042 SHALL verify: rst pulsed mid-beat -> all outputs 0 within the same cycle; after release, the first tick follows the 34-cycle CALC latency.
REQ-043 SHALL verify (macro on): bpm=60, subdiv=3 -> sub_tick at counts 0, 333, 666 of each 1000-cycle beat.
